// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared FIFO definitions: depth helper, drop counter width and
//                status flag bit order used by the lane status aggregator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DROP_CNT_W = 8;

    // Status flag vector layout
    localparam int FLAG_W            = 4;
    localparam int FLAG_FULL         = 0;
    localparam int FLAG_EMPTY        = 1;
    localparam int FLAG_ALMOST_FULL  = 2;
    localparam int FLAG_ALMOST_EMPTY = 3;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_umbral_flags.sv
// ============================================================================
//  Module      : fifo_umbral_flags
//  Description : Combinational FIFO status flags from occupancy and the
//                programmable almost-full / almost-empty thresholds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_umbral_flags
    import fifo_pkg::*;
#(
    parameter int address_width = 3
) (
    input  logic [address_width:0] cnt_i,
    input  logic [address_width:0] umbral_full_i,
    input  logic [address_width:0] umbral_empty_i,
    output logic [FLAG_W-1:0]      flags_o
);

    localparam logic [address_width:0] c_DEPTH =
        (address_width+1)'(fifo_depth(address_width));

    // A zero almost-full threshold naturally holds the flag high
    always_comb begin
        flags_o                    = '0;
        flags_o[FLAG_FULL]         = (cnt_i == c_DEPTH);
        flags_o[FLAG_EMPTY]        = (cnt_i == '0);
        flags_o[FLAG_ALMOST_FULL]  = (cnt_i >= umbral_full_i);
        flags_o[FLAG_ALMOST_EMPTY] = (cnt_i <= umbral_empty_i);
    end

endmodule

`default_nettype wire

// File: rtl/fifo_umbral_gen.sv
// ============================================================================
//  Module      : fifo_umbral_gen
//  Description : Synchronous FIFO with programmable thresholds, sticky
//                overflow/underflow error and registered read data.
//                Optional FIFO_DROP_CNT_EN adds a saturating drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_umbral_gen
    import fifo_pkg::*;
#(
    parameter int data_width    = 6,
    parameter int address_width = 3
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     wr_enable,
    input  logic                     rd_enable,
    input  logic [data_width-1:0]    data_in,
    input  logic [address_width:0]   umbral_full,
    input  logic [address_width:0]   umbral_empty,
    output logic [data_width-1:0]    data_out,
    output logic                     valid_out,
    output logic                     full_fifo,
    output logic                     empty_fifo,
    output logic                     almost_full_fifo,
    output logic                     almost_empty_fifo,
    output logic                     error,
`ifdef FIFO_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0]    drop_cnt,
`endif
    output logic [address_width:0]   fifo_cnt
);

    localparam int c_DEPTH = fifo_depth(address_width);

    logic [data_width-1:0]    mem_q [c_DEPTH];
    logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [address_width:0]   cnt_q, cnt_d;
    logic [data_width-1:0]    data_out_q, data_out_d;
    logic                     valid_q, valid_d;
    logic                     error_q, error_d;

    logic [FLAG_W-1:0]        flags;
    logic                     wr_acc, rd_acc, overflow, underflow;

    fifo_umbral_flags #(
        .address_width (address_width)
    ) u_flags (
        .cnt_i          (cnt_q),
        .umbral_full_i  (umbral_full),
        .umbral_empty_i (umbral_empty),
        .flags_o        (flags)
    );

    // A write into a full FIFO is still taken when a read frees a slot
    always_comb begin
        rd_acc    = rd_enable && !flags[FLAG_EMPTY];
        wr_acc    = wr_enable && (!flags[FLAG_FULL] || rd_acc);
        overflow  = wr_enable && flags[FLAG_FULL] && !rd_acc;
        underflow = rd_enable && flags[FLAG_EMPTY];
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        data_out_d = '0;
        valid_d    = 1'b0;
        error_d    = error_q | overflow | underflow;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + address_width'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + address_width'(1);
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + (address_width+1)'(1);
            2'b01:   cnt_d = cnt_q - (address_width+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Storage carries no reset; contents before the first write are don't-care
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((overflow || underflow) && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign data_out          = data_out_q;
    assign valid_out         = valid_q;
    assign error             = error_q;
    assign fifo_cnt          = cnt_q;
    assign full_fifo         = flags[FLAG_FULL];
    assign empty_fifo        = flags[FLAG_EMPTY];
    assign almost_full_fifo  = flags[FLAG_ALMOST_FULL];
    assign almost_empty_fifo = flags[FLAG_ALMOST_EMPTY];

endmodule

`default_nettype wire
